// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional macro DELAY_SLOT_EN keeps the delay-slot fetch on a taken redirect instead of squashing it.
module inst_fetch_unit #(
  parameter int          Inst_Num_BIT = 8,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [Inst_Num_BIT-1:0] Inst_Address,
  input  logic [31:0]             Instruction,
  input  logic                    Stall,
  input  logic                    Redirect,
  input  logic [31:0]             Redirect_Target,
  output logic [31:0]             IFID_Instruction,
  output logic [31:0]             IFID_PC_Plus_4,
  output logic                    IFID_Valid,
  output logic [31:0]             PC,
  output logic                    Fault
);

  localparam int ADDR_BITS = Inst_Num_BIT + 2;
  // Byte-address span covered by the instruction memory; bits above it must stay zero.
  localparam logic [32:0] LOW_MASK = (ADDR_BITS >= 32) ? 33'h0_FFFF_FFFF
                                                       : ((33'h1 << ADDR_BITS) - 33'h1);
  localparam logic [31:0] HI_MASK  = ~LOW_MASK[31:0];
  localparam bit          SEQ_CHK  = (ADDR_BITS < 32);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus_4;
  logic [32:0] low_sum;
  logic        seq_carry;
  logic        tgt_bad;
  ifid_t       fetch_ent, bubble_ent, redir_ent;

  assign pc_plus_4 = pc_q + 32'd4;
  assign low_sum   = ({1'b0, pc_q} & LOW_MASK) + 33'd4;
  assign seq_carry = SEQ_CHK && (low_sum > LOW_MASK);
  assign tgt_bad   = (Redirect_Target[1:0] != 2'b00) || ((Redirect_Target & HI_MASK) != 32'h0);

  assign fetch_ent  = '{instr: Instruction, pc4: pc_plus_4, valid: 1'b1};
  assign bubble_ent = '{instr: 32'h0,       pc4: pc_plus_4, valid: 1'b0};
`ifdef DELAY_SLOT_EN
  assign redir_ent  = fetch_ent;
`else
  assign redir_ent  = bubble_ent;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: begin
        // PC is held, so this edge latches the word at RESET_PC.
        ifid_d  = fetch_ent;
        state_d = RUN;
      end
      RUN: begin
        if (!Stall) begin
          if (Redirect) begin
            if (tgt_bad) begin
              ifid_d  = bubble_ent;
              fault_d = 1'b1;
              state_d = HALT;
            end else begin
              pc_d   = Redirect_Target;
              ifid_d = redir_ent;
            end
          end else if (seq_carry) begin
            ifid_d  = bubble_ent;
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d   = pc_plus_4;
            ifid_d = fetch_ent;
          end
        end
      end
      HALT: ifid_d = bubble_ent;
      default: begin
        ifid_d  = bubble_ent;
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
    end
  end

  assign Inst_Address     = pc_q[Inst_Num_BIT+1:2];
  assign PC               = pc_q;
  assign IFID_Instruction = ifid_q.instr;
  assign IFID_PC_Plus_4   = ifid_q.pc4;
  assign IFID_Valid       = ifid_q.valid;
  assign Fault            = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes hand-computed expectations, monitor pops and compares.
module tb_inst_fetch_unit;
  localparam int IB = 8;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IB-1:0] Inst_Address;
  logic [31:0]   Instruction;
  logic          Stall = 1'b0;
  logic          Redirect = 1'b0;
  logic [31:0]   Redirect_Target = 32'h0;
  logic [31:0]   IFID_Instruction, IFID_PC_Plus_4, PC;
  logic          IFID_Valid, Fault;

  inst_fetch_unit #(.Inst_Num_BIT(IB), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .Stall(Stall), .Redirect(Redirect), .Redirect_Target(Redirect_Target),
    .IFID_Instruction(IFID_Instruction), .IFID_PC_Plus_4(IFID_PC_Plus_4),
    .IFID_Valid(IFID_Valid), .PC(PC), .Fault(Fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [IB-1:0] a);
    return (a == '0) ? 32'h3C01_6165 : (32'hA000_0000 | {24'h0, a});
  endfunction

  function automatic logic [31:0] rdi(input logic [IB-1:0] a);
    return DS ? mem_word(a) : 32'h0;
  endfunction

  assign Instruction = mem_word(Inst_Address);

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
    logic        f;
    logic        chk4;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  event ev_async;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  task automatic compare(input exp_t e);
    logic [IB-1:0] ia_exp;
    logic [31:0]   pc4_e;
    ia_exp = e.pc[IB+1:2];
    pc4_e  = e.chk4 ? e.pc4 : IFID_PC_Plus_4;
    n_chk++;
    if (PC !== e.pc || Inst_Address !== ia_exp || IFID_Instruction !== e.instr ||
        IFID_PC_Plus_4 !== pc4_e || IFID_Valid !== e.v || Fault !== e.f) begin
      n_fail++;
      $display("FAIL %s: got pc=%h ia=%h instr=%h pc4=%h v=%b f=%b, want pc=%h ia=%h instr=%h pc4=%h v=%b f=%b",
               e.name, PC, Inst_Address, IFID_Instruction, IFID_PC_Plus_4, IFID_Valid, Fault,
               e.pc, ia_exp, e.instr, pc4_e, e.v, e.f);
    end
  endtask

  // Monitor: the only process that compares and touches the counters.
  initial begin
    forever begin
      @(posedge clk or ev_async);
      if (aq.size() > 0) begin
        #1;
        compare(aq.pop_front());
      end else begin
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s: expectation due at cycle %0d never checked (now %0d)", q[0].name, q[0].due, cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) compare(q.pop_front());
        if (done) begin
          n_chk++;
          if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
          end
          $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
          $finish;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary, want completion");
    $fatal(1, "timeout");
  end

  // Drive inputs mid-cycle, queue the state expected after the next rising edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt,
                      input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                      input logic v, input logic f, input logic chk4, input string name);
    exp_t e;
    Stall = st; Redirect = rd; Redirect_Target = tgt;
    e.due = cyc + 1; e.pc = pc; e.instr = instr; e.pc4 = pc4;
    e.v = v; e.f = f; e.chk4 = chk4; e.name = name;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset(input string name);
    exp_t e;
    reset = 1'b0;
    e.due = 0; e.pc = 32'h0; e.instr = 32'h0; e.pc4 = 32'h0;
    e.v = 1'b0; e.f = 1'b0; e.chk4 = 1'b1; e.name = name;
    aq.push_back(e);
    -> ev_async;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #2;
    step(0, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 1, "in_reset");
    reset = 1'b1;
    step(0, 0, 0, 32'h0, 32'h3C01_6165, 32'h4, 1, 0, 1, "boot");
    step(0, 0, 0, 32'h4, mem_word(0), 32'h4, 1, 0, 1, "run0");
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 32'(4*(k+1)), mem_word(IB'(k)), 32'(4*(k+1)), 1, 0, 1, "seq");
    step(0, 1, 32'h34, 32'h34, rdi(6),  32'h1C, DS, 0, 1, "redir34");
    step(0, 1, 32'h40, 32'h40, rdi(13), 32'h38, DS, 0, 1, "jal40");
    step(0, 1, 32'h50, 32'h50, rdi(16), 32'h44, DS, 0, 1, "redir50");
    for (int k = 0; k < 3; k++)
      step(1, 1, 32'h60, 32'h50, rdi(16), 32'h44, DS, 0, 1, "stall");
    step(0, 0, 0, 32'h54, mem_word(20), 32'h54, 1, 0, 1, "unstall");
    step(0, 1, 32'h42, 32'h54, 32'h0, 32'h0, 0, 1, 0, "misalign");
    step(0, 1, 32'h40, 32'h54, 32'h0, 32'h0, 0, 1, 0, "halt_redir");
    step(0, 0, 0,      32'h54, 32'h0, 32'h0, 0, 1, 0, "halt_seq");

    async_reset("async_rst1");
    step(0, 1, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 1, "held_rst1");
    reset = 1'b1;
    step(0, 0, 0, 32'h0, 32'h3C01_6165, 32'h4, 1, 0, 1, "boot2");
    step(0, 0, 0, 32'h4, mem_word(0), 32'h4, 1, 0, 1, "run2");
    step(0, 1, 32'h400, 32'h4, 32'h0, 32'h0, 0, 1, 0, "range");

    async_reset("async_rst2");
    step(1, 1, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 1, "held_rst2");
    reset = 1'b1;
    step(0, 0, 0, 32'h0, 32'h3C01_6165, 32'h4, 1, 0, 1, "boot3");
    step(0, 1, 32'h3FC, 32'h3FC, rdi(0), 32'h4, DS, 0, 1, "to3fc");
    step(0, 0, 0, 32'h3FC, 32'h0, 32'h0, 0, 1, 0, "seq_ovf");
    step(0, 0, 0, 32'h3FC, 32'h0, 32'h0, 0, 1, 0, "halt_3fc");

    Stall = 1'b0; Redirect = 1'b0;
    done = 1'b1;
  end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter Inst_Num_BIT, default 8, width of the instruction-memory word address.
REQ-002 Parameter RESET_PC, default 32'h00000000, byte address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Inst_Address  output  Inst_Num_BIT  word address to instruction memory, equal to PC[Inst_Num_BIT+1:2].
REQ-006 Instruction  input  32  instruction word returned combinationally by instruction memory for Inst_Address.
REQ-007 Stall  input  1  hazard hold from decode; freezes PC and IF/ID.
REQ-008 Redirect  input  1  taken branch or jump resolved in decode.
REQ-009 Redirect_Target  input  32  byte target address, valid while Redirect=1.
REQ-010 IFID_Instruction  output  32  registered fetched instruction.
REQ-011 IFID_PC_Plus_4  output  32  registered byte address of that instruction plus 4.
REQ-012 IFID_Valid  output  1  IF/ID holds a real instruction; 0 means a bubble (IFID_Instruction = 0).
REQ-013 PC  output  32  current fetch byte address.
REQ-014 Fault  output  1  sticky fetch fault.

Function
REQ-015 FSM states: BOOT, RUN, HALT.
REQ-016 BOOT lasts exactly one cycle after reset release: PC held, IF/ID loaded with Instruction at RESET_PC, IFID_Valid<=1; then RUN.
REQ-017 RUN, Stall=0, Redirect=0: PC<=PC+4; IF/ID<={Instruction, PC+4, valid=1}.
REQ-018 RUN, Stall=1: PC, IF/ID and state unchanged; Redirect ignored in the same cycle (decode reasserts after stall).
REQ-019 RUN, Stall=0, Redirect=1: PC<=Redirect_Target; IF/ID loading per REQ-030/031.
REQ-020 Latency: instruction at address A appears in IF/ID one cycle after PC=A with Stall=0.
REQ-021 PC+4 wraps modulo 2^32 with no flag.
REQ-022 Fault set, state->HALT, when a redirect is accepted with Redirect_Target[1:0]!=0, or Redirect_Target[31:Inst_Num_BIT+2]!=0.
REQ-023 Fault set, state->HALT, when sequential PC+4 carries out of the Inst_Num_BIT+2 low bits.
REQ-024 Faulting cycle: PC unchanged, IF/ID loaded with a bubble.
REQ-025 HALT: PC frozen, IF/ID bubble every cycle, all inputs ignored; exit only by reset.
REQ-026 Inst_Address combinational from PC only; no dependency on Stall or Redirect in the same cycle.

Reset
REQ-027 While reset=0: PC=RESET_PC, state=BOOT, IFID_Instruction=0, IFID_PC_Plus_4=0, IFID_Valid=0, Fault=0.
REQ-028 Reset asserted mid-operation overrides any pending Redirect/Stall immediately, without waiting for clk.
REQ-029 First rising edge with reset=1 performs the BOOT action.

Configuration
REQ-030 Macro DELAY_SLOT_EN defined: on accepted redirect, IF/ID loads the instruction currently fetched (delay slot, PC+4 of branch), IFID_Valid=1.
REQ-031 DELAY_SLOT_EN undefined: on accepted redirect, IF/ID loads a bubble (Instruction 0, IFID_Valid=0), discarding the delay-slot fetch.

Verification
REQ-032 Reset low then release, Instruction=32'h3C016165 at word 0 -> after BOOT: IFID_Instruction=32'h3C016165, IFID_PC_Plus_4=4, PC=0; next cycle PC=4.
REQ-033 Sequential run words 0..5, no stall -> Inst_Address 0,1,2,3,4,5 on consecutive cycles, IFID_PC_Plus_4 4,8,...,24.
REQ-034 PC=0x34 (jal delay slot), Redirect=1, target 0x40 -> next: PC=0x40, Inst_Address=16; IFID_PC_Plus_4=0x38, IFID_Valid=1 with DELAY_SLOT_EN, IFID_Valid=0 without.
REQ-035 Stall=1 for 3 cycles at PC=0x50 with Redirect=1 during stall -> PC stays 0x50, IF/ID unchanged; Stall=0, Redirect=0 -> PC=0x54.
REQ-036 Redirect to 0x42 -> Fault=1, IFID_Valid=0, PC unchanged; further Redirect to 0x40 ignored; reset clears Fault, PC=0.
REQ-037 Inst_Num_BIT=8, sequential PC=0x3FC -> Fault=1, HALT, PC stays 0x3FC.
